// File: rtl/arith_pkg.sv
// Shared arithmetic package for the sequential divider/multiplier family.
//
// Contents:
//   ARITH_WIDTH   - default operand width (two's complement bits)
//   arith_state_t - handshake FSM encoding: IDLE, LOOP, FIX, DONE, WAIT
//   sign_mag_t    - sign bit plus unsigned magnitude of an ARITH_WIDTH operand
//   sign_mag()    - converts a signed operand to sign/magnitude form; the most
//                   negative value maps to its true magnitude (-128 -> 128),
//                   which fits because the magnitude field is unsigned.
package arith_pkg;

    localparam int ARITH_WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOOP = 3'd1,
        FIX  = 3'd2,
        DONE = 3'd3,
        WAIT = 3'd4
    } arith_state_t;

    typedef struct packed {
        logic                   sign;
        logic [ARITH_WIDTH-1:0] mag;
    } sign_mag_t;

    function automatic sign_mag_t sign_mag(input logic [ARITH_WIDTH-1:0] value);
        sign_mag_t r;
        r.sign = value[ARITH_WIDTH-1];
        r.mag  = r.sign ? (~value + 1'b1) : value;
        return r;
    endfunction

endpackage

// File: rtl/multiplier_datapath.sv
// Shift-add datapath of the sequential signed multiplier.
//
// Holds the operand magnitudes, the result sign, the 2*WIDTH accumulator, the
// iteration counter and the Product register. The controlling FSM drives it
// with three strobes:
//   load  - capture |a|, |b|, sign(a) ^ sign(b) (and addend); clear acc/counter
//   step  - one shift-add iteration
//   fix   - apply the sign (and addend) to the accumulator into product
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears all state)
//   load/step/fix   FSM strobes
//   a, b            signed operands, only looked at while load is high
//   addend          signed addend (only with MULTIPLIER_ADDEND_EN)
//   last            high while the counter is on the final iteration
//   product         signed 2*WIDTH result, held between operations
//
// Optional feature macro: MULTIPLIER_ADDEND_EN.
module multiplier_datapath
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               fix,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef MULTIPLIER_ADDEND_EN
    input  logic [WIDTH-1:0]   addend,
`endif
    output logic               last,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               sign;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] product_q;
    logic [2*WIDTH-1:0] fixed;
    logic [2*WIDTH-1:0] wide_a;

`ifdef MULTIPLIER_ADDEND_EN
    logic [WIDTH-1:0]   addend_q;
`endif

    // The package helper is sized for the default width; other widths use
    // the same two's complement rule written inline.
    generate
        if (WIDTH == ARITH_WIDTH) begin : g_pkg_sm
            sign_mag_t sm_a;
            sign_mag_t sm_b;
            assign sm_a   = sign_mag(a);
            assign sm_b   = sign_mag(b);
            assign sign_a = sm_a.sign;
            assign sign_b = sm_b.sign;
            assign abs_a  = sm_a.mag;
            assign abs_b  = sm_b.mag;
        end else begin : g_inline_sm
            assign sign_a = a[WIDTH-1];
            assign sign_b = b[WIDTH-1];
            assign abs_a  = sign_a ? (~a + 1'b1) : a;
            assign abs_b  = sign_b ? (~b + 1'b1) : b;
        end
    endgenerate

    assign wide_a = {{WIDTH{1'b0}}, mag_a};
    assign last   = (cnt == CNT_W'(WIDTH - 1));

    // Negating a zero accumulator yields zero, so no special case is needed.
    always_comb begin
        fixed = sign ? (~acc + 1'b1) : acc;
`ifdef MULTIPLIER_ADDEND_EN
        fixed = fixed + {{WIDTH{addend_q[WIDTH-1]}}, addend_q};
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag_a     <= '0;
            mag_b     <= '0;
            sign      <= 1'b0;
            acc       <= '0;
            cnt       <= '0;
            product_q <= '0;
`ifdef MULTIPLIER_ADDEND_EN
            addend_q  <= '0;
`endif
        end else begin
            if (load) begin
                mag_a    <= abs_a;
                mag_b    <= abs_b;
                sign     <= sign_a ^ sign_b;
                acc      <= '0;
                cnt      <= '0;
`ifdef MULTIPLIER_ADDEND_EN
                addend_q <= addend;
`endif
            end else if (step) begin
                // mag_b is consumed LSB first; cnt is the weight of that bit.
                if (mag_b[0]) begin
                    acc <= acc + (wide_a << cnt);
                end
                mag_b <= mag_b >> 1;
                cnt   <= cnt + 1'b1;
            end
            if (fix) begin
                product_q <= fixed;
            end
        end
    end

    assign product = product_q;

endmodule

// File: rtl/multiplier_module.sv
// Signed WIDTH x WIDTH sequential shift-add multiplier with Start_Sig/Done_Sig
// request/acknowledge handshake.
//
// Ports:
//   CLK           rising-edge clock
//   RSTn          asynchronous active-low reset
//   Start_Sig     request, held high by the initiator until it sees Done_Sig
//   Multiplicand  signed operand A, sampled at the capture edge only
//   Multiplier    signed operand B, sampled at the capture edge only
//   Addend        signed addend, sign-extended into the result
//                 (only with MULTIPLIER_ADDEND_EN)
//   Done_Sig      one-cycle completion pulse
//   Product       signed 2*WIDTH result, held until the next completion
//
// Timing: capture edge, WIDTH iteration edges, one fix edge that updates
// Product and raises Done_Sig, then DONE and WAIT. A new request is accepted
// only after Start_Sig has been seen low in WAIT.
//
// Optional feature macro: MULTIPLIER_ADDEND_EN.
module multiplier_module
    import arith_pkg::*;
#(
    parameter int WIDTH = ARITH_WIDTH
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               Start_Sig,
    input  logic [WIDTH-1:0]   Multiplicand,
    input  logic [WIDTH-1:0]   Multiplier,
`ifdef MULTIPLIER_ADDEND_EN
    input  logic [WIDTH-1:0]   Addend,
`endif
    output logic               Done_Sig,
    output logic [2*WIDTH-1:0] Product
);

    arith_state_t state_q;
    arith_state_t state_d;
    logic         load;
    logic         step;
    logic         fix;
    logic         last;
    logic         done_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            // Done rises on the fix edge and falls on the following edge.
            done_q  <= fix;
        end
    end

    // Start_Sig is only examined in IDLE and WAIT, so dropping it mid
    // operation has no effect and holding it high cannot retrigger.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        fix     = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start_Sig) begin
                    load    = 1'b1;
                    state_d = LOOP;
                end
            end
            LOOP: begin
                step = 1'b1;
                if (last) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                fix     = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!Start_Sig) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    multiplier_datapath #(
        .WIDTH   (WIDTH)
    ) u_datapath (
        .clk     (CLK),
        .rst_n   (RSTn),
        .load    (load),
        .step    (step),
        .fix     (fix),
        .a       (Multiplicand),
        .b       (Multiplier),
`ifdef MULTIPLIER_ADDEND_EN
        .addend  (Addend),
`endif
        .last    (last),
        .product (Product)
    );

    assign Done_Sig = done_q;

endmodule

// File: tb/tb_multiplier_module.sv
// Self-checking bench for multiplier_module: directed corner products,
// randomized operands against an arithmetic reference, operand changes after
// capture, asynchronous reset mid-operation and a continuously held request.
// Addend scenarios are compiled in when MULTIPLIER_ADDEND_EN is defined.
module tb_multiplier_module;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b1;
    logic        Start_Sig = 1'b0;
    logic [7:0]  Multiplicand = '0;
    logic [7:0]  Multiplier = '0;
    logic [7:0]  Addend = '0;
    logic        Done_Sig;
    logic [15:0] Product;

    int checks = 0;
    int failures = 0;

    multiplier_module #(.WIDTH(8)) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .Start_Sig    (Start_Sig),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
`ifdef MULTIPLIER_ADDEND_EN
        .Addend       (Addend),
`endif
        .Done_Sig     (Done_Sig),
        .Product      (Product)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain integer product (plus addend in that build), 16 bits.
    function automatic logic [15:0] ref_product(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] ad);
        int r;
        r = int'($signed(a)) * int'($signed(b));
`ifdef MULTIPLIER_ADDEND_EN
        r = r + int'($signed(ad));
`else
        if (ad === 8'hxx) r = 0;
`endif
        return r[15:0];
    endfunction

    // Drives one full handshake. Returns the product seen when Done_Sig is
    // first high, the number of edges from capture to that point (-1 on
    // timeout) and how many of the two following samples still saw Done_Sig.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] ad,
                          input bit scramble, output logic [15:0] prod,
                          output int lat, output int extra_high);
        Multiplicand = a;
        Multiplier   = b;
        Addend       = ad;
        Start_Sig    = 1'b1;
        @(posedge CLK); #1;
        if (scramble) begin
            Multiplicand = 8'($urandom);
            Multiplier   = 8'($urandom);
            Addend       = 8'($urandom);
        end
        lat = -1;
        extra_high = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (Done_Sig) begin
                lat = i;
                break;
            end
        end
        prod = Product;
        Start_Sig = 1'b0;
        @(posedge CLK); #1;
        if (Done_Sig) extra_high++;
        @(posedge CLK); #1;
        if (Done_Sig) extra_high++;
    endtask

    task automatic test_reset();
        @(posedge CLK); #1;
        RSTn = 1'b0;
        #1;
        checks++;
        if (Done_Sig !== 1'b0) begin
            failures++;
            $display("FAIL reset_done: got %b want 0", Done_Sig);
        end
        checks++;
        if (Product !== 16'h0000) begin
            failures++;
            $display("FAIL reset_product: got %h want 0000", Product);
        end
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (Done_Sig !== 1'b0 || Product !== 16'h0000) begin
            failures++;
            $display("FAIL post_reset_idle: got done=%b product=%h want done=0 product=0000",
                     Done_Sig, Product);
        end
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] expect_p;
    } vec_t;

    task automatic test_directed();
        vec_t vecs[6];
        logic [15:0] p;
        int lat;
        int extra;
        vecs[0] = '{8'd13,  8'd2,   16'h001A};
        vecs[1] = '{8'd13,  8'hFE,  16'hFFE6};
        vecs[2] = '{8'hF3,  8'hFE,  16'h001A};
        vecs[3] = '{8'h80,  8'h80,  16'h4000};
        vecs[4] = '{8'h80,  8'h7F,  16'hC080};
        vecs[5] = '{8'h00,  8'hFB,  16'h0000};
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, 8'h00, 1'b0, p, lat, extra);
            checks++;
            if (p !== vecs[i].expect_p) begin
                failures++;
                $display("FAIL directed_product[%0d] %h*%h: got %h want %h",
                         i, vecs[i].a, vecs[i].b, p, vecs[i].expect_p);
            end
            checks++;
            if (lat !== 9) begin
                failures++;
                $display("FAIL directed_latency[%0d]: got %0d want 9", i, lat);
            end
            checks++;
            if (extra !== 0) begin
                failures++;
                $display("FAIL directed_done_width[%0d]: extra high samples %0d want 0", i, extra);
            end
        end
    endtask

`ifdef MULTIPLIER_ADDEND_EN
    task automatic test_addend();
        logic [15:0] p;
        int lat;
        int extra;
        run_op(8'hFA, 8'h02, 8'hFF, 1'b0, p, lat, extra);
        checks++;
        if (p !== 16'hFFF3) begin
            failures++;
            $display("FAIL addend_product: got %h want fff3", p);
        end
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL addend_latency: got %0d want 9", lat);
        end
        run_op(8'h7F, 8'h7F, 8'h7F, 1'b0, p, lat, extra);
        checks++;
        if (p !== 16'h3F80) begin
            failures++;
            $display("FAIL addend_max: got %h want 3f80", p);
        end
    endtask
`endif

    task automatic test_random();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  ad;
        logic [15:0] p;
        logic [15:0] e;
        int lat;
        int extra;
        for (int i = 0; i < 24; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            ad = 8'($urandom);
            e  = ref_product(a, b, ad);
            run_op(a, b, ad, 1'b0, p, lat, extra);
            checks++;
            if (p !== e || lat !== 9 || extra !== 0) begin
                failures++;
                $display("FAIL random[%0d] %h*%h+%h: got %h lat=%0d extra=%0d want %h lat=9 extra=0",
                         i, a, b, ad, p, lat, extra, e);
            end
        end
    endtask

    task automatic test_operand_change();
        logic [7:0]  a;
        logic [7:0]  b;
        logic [7:0]  ad;
        logic [15:0] p;
        logic [15:0] e;
        int lat;
        int extra;
        for (int i = 0; i < 4; i++) begin
            a  = 8'($urandom);
            b  = 8'($urandom);
            ad = 8'($urandom);
            e  = ref_product(a, b, ad);
            run_op(a, b, ad, 1'b1, p, lat, extra);
            checks++;
            if (p !== e) begin
                failures++;
                $display("FAIL operand_change[%0d] %h*%h: got %h want %h", i, a, b, p, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int lat;
        int extra;
        int pulses;
        run_op(8'h7F, 8'h7F, 8'h00, 1'b0, p, lat, extra);
        checks++;
        if (p !== ref_product(8'h7F, 8'h7F, 8'h00)) begin
            failures++;
            $display("FAIL pre_reset_product: got %h want %h", p, ref_product(8'h7F, 8'h7F, 8'h00));
        end
        Multiplicand = 8'd5;
        Multiplier   = 8'd7;
        Start_Sig    = 1'b1;
        @(posedge CLK);          // capture
        repeat (4) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        checks++;
        if (Product !== 16'h0000 || Done_Sig !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_immediate: got product=%h done=%b want 0000 0",
                     Product, Done_Sig);
        end
        Start_Sig = 1'b0;
        @(posedge CLK); #1;
        RSTn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK); #1;
            if (Done_Sig) pulses++;
        end
        checks++;
        if (pulses !== 0 || Product !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mid_no_done: got pulses=%0d product=%h want 0 0000", pulses, Product);
        end
        run_op(8'hF7, 8'h06, 8'h00, 1'b0, p, lat, extra);
        checks++;
        if (p !== ref_product(8'hF7, 8'h06, 8'h00) || lat !== 9) begin
            failures++;
            $display("FAIL reset_mid_recover: got %h lat=%0d want %h lat=9",
                     p, lat, ref_product(8'hF7, 8'h06, 8'h00));
        end
    endtask

    task automatic test_start_held();
        int lat;
        int pulses;
        logic [15:0] e1;
        logic [15:0] e2;
        e1 = ref_product(8'd11, 8'hF9, 8'h00);
        e2 = ref_product(8'h9C, 8'h21, 8'h00);
        Multiplicand = 8'd11;
        Multiplier   = 8'hF9;
        Addend       = 8'h00;
        Start_Sig    = 1'b1;
        @(posedge CLK); #1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (Done_Sig) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 9 || Product !== e1) begin
            failures++;
            $display("FAIL held_first: got %h lat=%0d want %h lat=9", Product, lat, e1);
        end
        Multiplicand = 8'h9C;
        Multiplier   = 8'h21;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (Done_Sig) pulses++;
        end
        checks++;
        if (pulses !== 0 || Product !== e1) begin
            failures++;
            $display("FAIL held_no_restart: got pulses=%0d product=%h want 0 %h", pulses, Product, e1);
        end
        Start_Sig = 1'b0;
        @(posedge CLK); #1;
        Start_Sig = 1'b1;
        @(posedge CLK); #1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK); #1;
            if (Done_Sig) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 9 || Product !== e2) begin
            failures++;
            $display("FAIL held_second: got %h lat=%0d want %h lat=9", Product, lat, e2);
        end
        Start_Sig = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
    endtask

    initial begin
        test_reset();
        test_directed();
`ifdef MULTIPLIER_ADDEND_EN
        test_addend();
`endif
        test_random();
        test_operand_change();
        test_reset_mid();
        test_start_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier_module.md
# multiplier_module

Signed 8×8 sequential shift-add multiplier with the same Start_Sig/Done_Sig request/acknowledge handshake as the divider blocks. It is the inverse datapath of the divider. With the optional addend it reconstructs Dividend = Quotient × Divisor + Reminder, which makes it both a general arithmetic unit and a self-check companion for divider results.

## Interface
- WIDTH, 8, operand width in bits (two's complement); product is 2×WIDTH.
- CLK  in  1  rising-edge clock.
- RSTn  in  1  asynchronous active-low reset.
- Start_Sig  in  1  request; initiator holds high until it samples Done_Sig high, then drops it.
- Multiplicand  in  WIDTH  signed operand A; sampled only at the capture edge.
- Multiplier  in  WIDTH  signed operand B; sampled only at the capture edge.
- Addend  in  WIDTH  signed, sign-extended and added to the product (present only with MULTIPLIER_ADDEND_EN).
- Done_Sig  out  1  one-cycle completion pulse.
- Product  out  2×WIDTH  signed result; held until the next operation completes.

## Operation
- States: IDLE, LOOP, FIX, DONE, WAIT.
- IDLE
  - Start_Sig sampled high is the capture edge.
  - Latch the magnitudes |A| and |B| as unsigned WIDTH bits, so −128 gives 128.
  - Latch sign = A[MSB] xor B[MSB] and, if present, the Addend.
  - Clear the accumulator and bit counter, then go to LOOP.
- LOOP: WIDTH iterations, one per clock.
  - If the current LSB of |B| is 1, add |A| shifted left by the counter into the 2×WIDTH accumulator.
  - Shift |B| right and increment the counter.
  - After the WIDTH-th iteration, go to FIX.
- FIX
  - Product = sign ? −acc : acc.
  - With MULTIPLIER_ADDEND_EN, add the sign-extended Addend in the same cycle.
  - Set Done_Sig to 1 and go to DONE.
- DONE: clear Done_Sig to 0 and go to WAIT.
- WAIT: stay until Start_Sig is sampled low, then go to IDLE. This guarantees one Done_Sig per request.
- Arithmetic and width rules:
  - Every result fits 2×WIDTH bits without overflow: (−128)×(−128) = 16384, 127×127 + 127 = 16256.
  - A negated zero stays 0.
- Boundary conditions:
  - Operand or Addend changes after capture: ignored.
  - Start_Sig dropped during LOOP or FIX: ignored; the operation completes and Done_Sig still pulses.
  - RSTn low at any point, including mid-LOOP: immediate return to IDLE; Done_Sig = 0, Product = 0, accumulator and counter cleared.
  - Start_Sig held high continuously: the block does not restart until it has seen Start_Sig low in WAIT.

## Timing
- Reset values: Done_Sig 0, Product 0, state IDLE.
- Capture edge T0 moves to LOOP.
- Edges T1..T8 are the iterations (WIDTH = 8).
- Edge T9 updates Product and raises Done_Sig.
- Edge T10 lowers Done_Sig; the initiator samples Done_Sig high at this edge and drops Start_Sig.
- Edge T11: WAIT samples Start_Sig low and moves to IDLE.
- Earliest next capture: T12.
- Latency: Product valid 9 cycles after capture.
- Done_Sig width: exactly one clock.
- Throughput: one operation per 12 cycles.

## Configuration
- Macro: MULTIPLIER_ADDEND_EN.
- Defined:
  - The Addend port exists and is captured at T0.
  - Product = signed(A×B) + sext(Addend).
- Undefined:
  - The Addend port and register are absent.
  - Product = signed(A×B).
  - Cycle timing is identical in both builds.

## Structure
- Shared package `arith_pkg` holds:
  - the state encoding typedef (IDLE/LOOP/FIX/DONE/WAIT), also used by the divider;
  - the default WIDTH constant;
  - a sign-magnitude helper function (abs value plus sign bit).
- One sub-module, `multiplier_datapath`:
  - holds the accumulator, shifter and counter;
  - is driven by load/step/fix strobes from the FSM in `multiplier_module`.

## Test plan
- 13 × 2, then 13 × −2 (0xFE), using the divider bench handshake → Product 0x001A, then 0xFFE6; Done_Sig high exactly one cycle, 9 cycles after each capture.
- −13 (0xF3) × −2, then −128 × −128 → 0x001A, then 0x4000; −128 × 127 → 0xC080.
- 0 × −5 → 0x0000; operands changed during LOOP → result unaffected.
- Build with MULTIPLIER_ADDEND_EN: Multiplicand −6 (0xFA), Multiplier 2, Addend −1 (0xFF) → 0xFFF3 (−13), reconstructing −13/2.
- RSTn pulsed low at T4 of an operation → Product 0 and Done_Sig 0 immediately; no Done_Sig pulse; the next request completes normally.
- Start_Sig held high after Done_Sig → no second Done_Sig until Start_Sig has been low for one cycle.
